// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer: decodes MIPS words at capture and
// steers them to integer, multiply or load/store issue queues.
module dispatch_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        Ifetch_valid,
  input  logic [31:0] Ifetch_inst,
  output logic        Ifetch_ready,
  input  logic        Flush,
  input  logic        Int_full,
  input  logic        Mult_full,
  input  logic        Ldst_full,
  output logic        Dispatch_en_integer,
  output logic        Dispatch_en_mult,
  output logic        Dispatch_en_ld_st,
  output logic [2:0]  Dispatch_opcode,
  output logic [4:0]  Dispatch_shfamt,
  output logic [15:0] Dispatch_imm_ld_st,
  output logic        Dispatch_illegal,
  output logic [7:0]  Stall_count
);

  typedef enum logic {
    EMPTY,
    HELD
  } state_e;

  typedef enum logic [1:0] {
    Q_INT,
    Q_MULT,
    Q_LDST,
    Q_NONE
  } tgt_e;

  state_e      state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  sh_q, sh_d;
  logic [15:0] imm_q, imm_d;
  logic        ill_q, ill_d;
  logic [7:0]  stall_q, stall_d;

  tgt_e        dec_tgt;
  logic [2:0]  dec_op;
  logic [5:0]  opc;
  logic [5:0]  fn;
  logic        tgt_full;
  logic        held;
  logic        issue;
  logic        capture;
  logic        unused_inst;

  assign opc = Ifetch_inst[31:26];
  assign fn  = Ifetch_inst[5:0];
  assign unused_inst = ^Ifetch_inst[25:16];

  // Instruction decode on the incoming word
  always_comb begin
    dec_tgt = Q_NONE;
    dec_op  = 3'b000;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000: begin dec_tgt = Q_INT;  dec_op = 3'b000; end
          6'b100001: begin dec_tgt = Q_INT;  dec_op = 3'b000; end
          6'b100010: begin dec_tgt = Q_INT;  dec_op = 3'b001; end
          6'b100100: begin dec_tgt = Q_INT;  dec_op = 3'b010; end
          6'b100101: begin dec_tgt = Q_INT;  dec_op = 3'b011; end
          6'b100111: begin dec_tgt = Q_INT;  dec_op = 3'b100; end
          6'b101010: begin dec_tgt = Q_INT;  dec_op = 3'b101; end
          6'b101011: begin dec_tgt = Q_INT;  dec_op = 3'b101; end
          6'b000000: begin dec_tgt = Q_INT;  dec_op = 3'b110; end
          6'b000010: begin dec_tgt = Q_INT;  dec_op = 3'b111; end
          6'b011000: begin dec_tgt = Q_MULT; dec_op = 3'b000; end
          default:   begin dec_tgt = Q_NONE; dec_op = 3'b000; end
        endcase
      end
      6'b001000: begin dec_tgt = Q_INT;  dec_op = 3'b000; end
      6'b001001: begin dec_tgt = Q_INT;  dec_op = 3'b000; end
      6'b001100: begin dec_tgt = Q_INT;  dec_op = 3'b010; end
      6'b001101: begin dec_tgt = Q_INT;  dec_op = 3'b011; end
      6'b001010: begin dec_tgt = Q_INT;  dec_op = 3'b101; end
      6'b000100: begin dec_tgt = Q_INT;  dec_op = 3'b001; end
      6'b000101: begin dec_tgt = Q_INT;  dec_op = 3'b001; end
      6'b000010: begin dec_tgt = Q_INT;  dec_op = 3'b000; end
      6'b100011: begin dec_tgt = Q_LDST; dec_op = 3'b000; end
      6'b101011: begin dec_tgt = Q_LDST; dec_op = 3'b001; end
      default:   begin dec_tgt = Q_NONE; dec_op = 3'b000; end
    endcase
  end

  // Only the full flag of the held entry's own queue matters
  always_comb begin
    tgt_full = 1'b1;
    case (tgt_q)
      Q_INT:   tgt_full = Int_full;
      Q_MULT:  tgt_full = Mult_full;
      Q_LDST:  tgt_full = Ldst_full;
      default: tgt_full = 1'b1;
    endcase
  end

  assign held    = (state_q == HELD);
  assign issue   = held & ~tgt_full & ~Flush & ~reset;
  assign Ifetch_ready = ~reset & ~Flush & (~held | issue);
  assign capture = Ifetch_valid & Ifetch_ready;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    op_d    = op_q;
    sh_d    = sh_q;
    imm_d   = imm_q;
    ill_d   = capture & (dec_tgt == Q_NONE);
    stall_d = stall_q;
    if (held && !issue && stall_q != 8'hff) begin
      stall_d = stall_q + 8'd1;
    end
    if (capture && dec_tgt != Q_NONE) begin
      state_d = HELD;
      tgt_d   = dec_tgt;
      op_d    = dec_op;
      sh_d    = Ifetch_inst[10:6];
      imm_d   = Ifetch_inst[15:0];
    end else if (issue || Flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      tgt_q   <= Q_INT;
      op_q    <= 3'b000;
      sh_q    <= 5'd0;
      imm_q   <= 16'd0;
      ill_q   <= 1'b0;
      stall_q <= 8'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
      stall_q <= stall_d;
    end
  end

  assign Dispatch_en_integer = issue & (tgt_q == Q_INT);
  assign Dispatch_en_mult    = issue & (tgt_q == Q_MULT);
  assign Dispatch_en_ld_st   = issue & (tgt_q == Q_LDST);
  assign Dispatch_opcode     = op_q;
  assign Dispatch_shfamt     = sh_q;
  assign Dispatch_imm_ld_st  = imm_q;
  assign Dispatch_illegal    = ill_q;
  assign Stall_count         = stall_q;

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-003 SHALL have port: Ifetch_valid  input  1  fetch stage presents an instruction.
REQ-004 SHALL have port: Ifetch_inst  input  32  MIPS instruction word (R/I/J format).
REQ-005 SHALL have port: Ifetch_ready  output  1  block accepts Ifetch_inst this cycle.
REQ-006 SHALL have port: Flush  input  1  discard the held instruction (branch mispredict).
REQ-007 SHALL have ports: Int_full, Mult_full, Ldst_full  input  1 each  target queue cannot accept.
REQ-008 SHALL have ports: Dispatch_en_integer, Dispatch_en_mult, Dispatch_en_ld_st  output  1 each  write strobe to the queue.
REQ-009 SHALL have port: Dispatch_opcode  output  3  ALU opcode; for ld/st, bit0 = 0 LD, 1 ST.
REQ-010 SHALL have port: Dispatch_shfamt  output  5  Inst[10:6] of held instruction.
REQ-011 SHALL have port: Dispatch_imm_ld_st  output  16  Inst[15:0] of held instruction.
REQ-012 SHALL have port: Dispatch_illegal  output  1  one-cycle pulse: unrecognised instruction dropped.
REQ-013 SHALL have port: Stall_count  output  8  saturating count of stalled cycles.

Function
REQ-014 SHALL hold at most one instruction in a holding register with a valid bit (states EMPTY, HELD).
REQ-015 SHALL transfer an instruction on a rising edge when Ifetch_valid & Ifetch_ready.
REQ-016 SHALL drive Ifetch_ready = !Flush & (EMPTY | issue this cycle); back-to-back transfer every cycle SHALL be possible.
REQ-017 SHALL classify at capture: opcode 000000 funct 011000 -> mult; opcode 100011 (lw) / 101011 (sw) -> ld/st; add, addu, sub, and, or, nor, slt, sltu, sll, srl, addi, addiu, andi, ori, slti, beq, bne, j -> integer; anything else -> illegal.
REQ-018 SHALL map the ALU opcode: add/addu/addi/addiu/j = 000; sub/beq/bne = 001; and/andi = 010; or/ori = 011; nor = 100; slt/sltu/slti = 101; sll = 110; srl = 111; mult = 000.
REQ-019 SHALL assert exactly one Dispatch_en_* (combinationally) when HELD, the target queue's full input is low and Flush is low; that is an issue, and the entry SHALL leave HELD at that edge unless refilled.
REQ-020 SHALL keep all Dispatch_* data outputs stable while HELD and not issued.
REQ-021 SHALL consume an illegal instruction at capture: no HELD entry, Dispatch_illegal high for the following cycle only.
REQ-022 SHALL, on Flush, deassert all Dispatch_en_*, accept nothing, and go EMPTY at the edge.
REQ-023 SHALL increment Stall_count at each edge where HELD and not issued; it SHALL saturate at 255.
REQ-024 SHALL ignore the full inputs of non-target queues.

Reset
REQ-025 SHALL, on reset, go EMPTY; Dispatch_en_* = 0, Dispatch_opcode = 000, Dispatch_shfamt = 0, Dispatch_imm_ld_st = 0, Dispatch_illegal = 0, Stall_count = 0.
REQ-026 SHALL let reset take priority over Flush and capture; an instruction held when reset asserts SHALL be discarded and never dispatched.
REQ-027 SHALL hold Ifetch_ready low during reset cycles.

Verification
REQ-028 SHALL pass: reset, then Ifetch_inst = 0x00851020 (add), all queues not full -> Dispatch_en_integer = 1 on the next cycle, opcode 000; Ifetch_ready stays 1.
REQ-029 SHALL pass: lw 0x8C820004 with Ldst_full = 1 for 3 cycles -> no strobe and Ifetch_ready = 0 for 3 cycles; Stall_count = 3; Dispatch_en_ld_st = 1, opcode bit0 = 0, imm = 0x0004 in cycle 4.
REQ-030 SHALL pass: mult 0x00850018 followed by sw 0xAC820008 on consecutive cycles -> Dispatch_en_mult, then Dispatch_en_ld_st with opcode bit0 = 1, no bubble.
REQ-031 SHALL pass: opcode 111111 -> Dispatch_illegal pulses for 1 cycle, no Dispatch_en_*.
REQ-032 SHALL pass: HELD sub with Int_full = 1, then Flush = 1 -> Dispatch_en_integer never asserts; state EMPTY; Ifetch_ready = 1 the next cycle.
REQ-033 SHALL pass: HELD instruction plus reset -> all outputs at their reset values at the next edge; 300 stall cycles -> Stall_count = 255.
